// File: rtl/miriscv_fetch_unit_if.sv
// Instruction-memory request/response bus plus the fetch-to-decode handshake.
interface miriscv_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            instr_req;
   logic [XLEN-1:0] instr_addr;
   logic            instr_gnt;
   logic            instr_rvalid;
   logic [XLEN-1:0] instr_rdata;
   logic            fetch_valid;
   logic [XLEN-1:0] fetch_instr;
   logic [XLEN-1:0] fetch_pc;
   logic            fetch_ready;

   modport master (
      output instr_req, instr_addr, fetch_valid, fetch_instr, fetch_pc,
      input  instr_gnt, instr_rvalid, instr_rdata, fetch_ready
   );

   modport slave (
      input  instr_req, instr_addr, fetch_valid, fetch_instr, fetch_pc,
      output instr_gnt, instr_rvalid, instr_rdata, fetch_ready
   );
endinterface

// File: rtl/miriscv_fetch_unit.sv
// In-order fetch front-end: PC generation, req/gnt/rvalid memory access and a
// DEPTH-entry {pc, instr} buffer, with redirect flushing buffered and in-flight words.
module miriscv_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                  clk_i,
   input  logic                  arstn_i,
   input  logic                  redirect_i,
   input  logic [XLEN-1:0]       redirect_pc_i,
   miriscv_fetch_unit_if.master  bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   count_q, count_d, out_q, out_d, disc_q, disc_d;
   logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [PW-1:0]   gwr_q, gwr_d, grd_q, grd_d;
   logic [DEPTH-1:0][XLEN-1:0] gpc_q, fpc_q, finstr_q;

   logic req, gnt_fire, rsp, drop, push, pop;

   // A slot is reserved for every outstanding grant, so the buffer can never overflow.
   always_comb begin
      req      = arstn_i && (({1'b0, count_q} + {1'b0, out_q}) < (CW+1)'(DEPTH));
      gnt_fire = req && bus.instr_gnt;
      rsp      = bus.instr_rvalid && (out_q != '0);
      drop     = redirect_i || (disc_q != '0);
      push     = rsp && !drop;
      pop      = (count_q != '0) && bus.fetch_ready;
   end

   always_comb begin
      pc_d    = pc_q;
      out_d   = out_q + CW'(gnt_fire) - CW'(rsp);
      gwr_d   = gwr_q + PW'(gnt_fire);
      grd_d   = grd_q + PW'(rsp);
      count_d = count_q + CW'(push) - CW'(pop);
      head_d  = head_q + PW'(pop);
      tail_d  = tail_q + PW'(push);
      disc_d  = disc_q - CW'(rsp && (disc_q != '0));
      if (gnt_fire) pc_d = pc_q + XLEN'(4);
      if (redirect_i) begin
         // Everything still in flight after this cycle belongs to the old stream.
         pc_d    = {redirect_pc_i[XLEN-1:2], 2'b00};
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
         disc_d  = out_d;
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         pc_q     <= RESET_PC;
         count_q  <= '0;
         out_q    <= '0;
         disc_q   <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         gwr_q    <= '0;
         grd_q    <= '0;
         gpc_q    <= '0;
         fpc_q    <= '0;
         finstr_q <= '0;
      end else begin
         pc_q    <= pc_d;
         count_q <= count_d;
         out_q   <= out_d;
         disc_q  <= disc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         gwr_q   <= gwr_d;
         grd_q   <= grd_d;
         if (gnt_fire) gpc_q[gwr_q] <= pc_q;
         if (push) begin
            fpc_q[tail_q]    <= gpc_q[grd_q];
            finstr_q[tail_q] <= bus.instr_rdata;
         end
      end
   end

   assign bus.instr_req   = req;
   assign bus.instr_addr  = pc_q;
   assign bus.fetch_valid = (count_q != '0);
   assign bus.fetch_instr = (count_q != '0) ? finstr_q[head_q] : '0;
   assign bus.fetch_pc    = (count_q != '0) ? fpc_q[head_q]    : '0;
endmodule

// File: tb/tb_miriscv_fetch_unit.sv
// Directed + random bench: a memory model answers grants in order, a scoreboard holds
// the {pc, instr} words the decode side should see.
module tb_miriscv_fetch_unit;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        arstn = 1'b0;
   logic        redir = 1'b0;
   logic [31:0] rpc = '0;

   miriscv_fetch_unit_if #(.XLEN(32)) bus ();

   miriscv_fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk_i         (clk),
      .arstn_i       (arstn),
      .redirect_i    (redir),
      .redirect_pc_i (rpc),
      .bus           (bus.master)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] mq[$];   // granted addresses awaiting response
   logic [31:0] sb[$];   // expected fetch PCs in order
   logic [31:0] mpc  = '0;
   int          mdisc = 0;
   logic gnt_en = 1'b0, rsp_en = 1'b0, rdy = 1'b0;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a * 32'd3) ^ 32'hC0DE_1357;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs();
      check("rst_req",   32'(bus.instr_req),   32'd0);
      check("rst_valid", 32'(bus.fetch_valid), 32'd0);
      check("rst_instr", bus.fetch_instr,      32'd0);
      check("rst_pc",    bus.fetch_pc,         32'd0);
   endtask

   // One clock cycle: entered and left just after a falling edge.
   task automatic cyc();
      logic g, rv, hs;
      logic [31:0] e;
      bus.instr_gnt    = gnt_en;
      bus.instr_rvalid = rsp_en && (mq.size() > 0);
      bus.instr_rdata  = bus.instr_rvalid ? word_of(mq[0]) : 32'h0;
      bus.fetch_ready  = rdy;
      #1;
      check("req", 32'(bus.instr_req), 32'((sb.size() + mq.size()) < DEPTH));
      if (bus.instr_req) check("addr", bus.instr_addr, mpc);
      check("fvalid", 32'(bus.fetch_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
         check("fpc",   bus.fetch_pc,    sb[0]);
         check("finstr", bus.fetch_instr, word_of(sb[0]));
      end else begin
         check("fpc_empty",   bus.fetch_pc,    32'h0);
         check("finstr_empty", bus.fetch_instr, 32'h0);
      end
      g  = bus.instr_req && bus.instr_gnt;
      rv = bus.instr_rvalid;
      hs = bus.fetch_valid && bus.fetch_ready;
      if (hs && sb.size() != 0) void'(sb.pop_front());
      if (rv) begin
         e = mq.pop_front();
         if (redir || mdisc != 0) begin
            if (mdisc != 0) mdisc--;
         end else sb.push_back(e);
      end
      if (g) begin
         mq.push_back(mpc);
         mpc = mpc + 32'd4;
      end
      if (redir) begin
         sb.delete();
         mdisc = mq.size();
         mpc = rpc & ~32'h3;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic redirect_to(input logic [31:0] pc);
      redir = 1'b1;
      rpc   = pc;
      cyc();
      redir = 1'b0;
   endtask

   initial begin
      bus.instr_gnt = 1'b0; bus.instr_rvalid = 1'b0; bus.instr_rdata = '0; bus.fetch_ready = 1'b0;
      #3;
      check_idle_outputs();
      repeat (2) @(negedge clk);
      arstn = 1'b1;

      // streaming fetch from reset
      gnt_en = 1; rsp_en = 1; rdy = 1;
      run(8);

      // back-pressure: buffer fills and req drops, single pop frees one slot
      rdy = 0;
      run(5);
      check("bp_req", 32'(bus.instr_req), 32'd0);
      rdy = 1; cyc(); rdy = 0;
      run(3);
      rdy = 1; run(4);

      // grant stall holds the address
      gnt_en = 0;
      redirect_to(32'h10);
      run(3);
      check("stall_addr", bus.instr_addr, 32'h10);
      gnt_en = 1; run(4);

      // redirect with two outstanding responses
      gnt_en = 0; rsp_en = 1; rdy = 1; run(4);
      gnt_en = 1; rsp_en = 0; run(3);
      redirect_to(32'h103);
      check("redir_addr", bus.instr_addr, 32'h100);
      rsp_en = 1; run(8);

      // redirect in the same cycle as a grant and a response
      redirect_to(32'h200);
      run(6);

      // address wrap at the top of the space
      redirect_to(32'hFFFF_FFFC);
      gnt_en = 0; run(1);
      check("top_addr", bus.instr_addr, 32'hFFFF_FFFC);
      gnt_en = 1; run(1);
      check("wrap_addr", bus.instr_addr, 32'h0);
      run(4);

      // randomized traffic with occasional redirects
      for (int i = 0; i < 300; i++) begin
         gnt_en = 1'($urandom_range(0, 1));
         rsp_en = 1'($urandom_range(0, 1));
         rdy    = 1'($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 15) == 0) redirect_to($urandom);
         else cyc();
      end

      // reset mid-transaction, memory is reset with the core
      gnt_en = 1; rsp_en = 0; rdy = 0; run(2);
      arstn = 1'b0;
      #1;
      check_idle_outputs();
      mq.delete(); sb.delete(); mdisc = 0; mpc = 32'h0;
      @(negedge clk);
      arstn = 1'b1;
      rsp_en = 1; rdy = 1; run(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
